// File: rtl/hidden_weight_update.sv
// -----------------------------------------------------------------------------
// hidden_weight_update
//
// Per-neuron hidden-layer weight update engine. On an accepted start the
// neuron's signed derivative is latched, then every input index is streamed:
// the pixel and the stored weight are read, and the weight is rewritten as
//     w_new = sat(w - ((deriv * pixel) >>> LR_SHIFT))
// One weight is processed per clock. The read-to-write latency is 2 cycles.
//
// Ports
//   clk         rising-edge clock
//   reset_b     asynchronous active-low reset
//   start       update request. Accepted in IDLE, and in FIN so that a
//               held start re-triggers every NINPUT+3 cycles.
//   derivative  signed derivative (NWBITS+1 bits), latched on acceptance
//   busy        high from the cycle after acceptance through the last write
//   done        one-cycle completion pulse
//   rd_en       read strobe shared by the pixel and weight memories
//   rd_addr     shared read index
//   pixel       unsigned pixel, valid the cycle after rd_en
//   w_rd_data   signed stored weight, valid the cycle after rd_en
//   wr_en       weight write strobe (weight memory must be dual-port)
//   wr_addr     weight write index
//   wr_data     updated, saturated weight
// -----------------------------------------------------------------------------
module hidden_weight_update #(
    parameter int NWBITS   = 16,
    parameter int PIXBITS  = 8,
    parameter int NINPUT   = 784,
    parameter int ABITS    = 10,
    parameter int LR_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     start,
    input  logic signed [NWBITS:0]   derivative,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ABITS-1:0]         rd_addr,
    input  logic [PIXBITS-1:0]       pixel,
    input  logic signed [NWBITS-1:0] w_rd_data,
    output logic                     wr_en,
    output logic [ABITS-1:0]         wr_addr,
    output logic signed [NWBITS-1:0] wr_data
);

    localparam int PBITS = NWBITS + PIXBITS + 2;   // product width
    localparam int DBITS = PBITS + 1;              // difference width
    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(NINPUT - 1);
    localparam logic signed [DBITS-1:0] W_MAX = DBITS'((2 ** (NWBITS - 1)) - 1);
    localparam logic signed [DBITS-1:0] W_MIN = ~W_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ABITS-1:0]         cnt_q, cnt_d;
    logic signed [NWBITS:0]   d_q, d_d;

    // Stage A: delayed read strobe/index, aligned with returning memory data.
    logic                     v1_q;
    logic [ABITS-1:0]         a1_q;

    // Stage B: registered write port.
    logic                     wr_en_q;
    logic [ABITS-1:0]         wr_addr_q;
    logic signed [NWBITS-1:0] wr_data_q;

    // ---------------------------------------------------------------------
    // Next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d   = derivative;
                    cnt_d = '0;
                    // A zero derivative leaves every weight unchanged, so the
                    // read pass is skipped. DRAIN is entered with an empty
                    // pipeline, which yields one busy cycle then done.
                    state_d = (derivative != '0) ? RUN : DRAIN;
                end
            end

            RUN: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = cnt_q;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                busy = 1'b1;
                // Once stage A is empty, the last write is on the write port
                // this cycle, so completion follows next cycle.
                if (!v1_q) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
                // Accepting here gives the NINPUT+3 back-to-back period.
                if (start) begin
                    d_d     = derivative;
                    cnt_d   = '0;
                    state_d = (derivative != '0) ? RUN : DRAIN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Update arithmetic (combinational from memory data and latched deriv)
    // ---------------------------------------------------------------------
    logic signed [PIXBITS:0]   pix_s;
    logic signed [PBITS-1:0]   prod;
    logic signed [PBITS-1:0]   delta;
    logic signed [DBITS-1:0]   diff;
    logic signed [NWBITS-1:0]  sat_w;

    always_comb begin
        pix_s = {1'b0, pixel};
        prod  = PBITS'(d_q) * PBITS'(pix_s);
        // Arithmetic shift of a two's-complement value floors toward -inf.
        delta = prod >>> LR_SHIFT;
        diff  = DBITS'(w_rd_data) - DBITS'(delta);
        if (diff > W_MAX) begin
            sat_w = {1'b0, {(NWBITS-1){1'b1}}};
        end else if (diff < W_MIN) begin
            sat_w = {1'b1, {(NWBITS-1){1'b0}}};
        end else begin
            sat_w = diff[NWBITS-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // State, latched derivative and write pipeline
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            d_q       <= '0;
            v1_q      <= 1'b0;
            a1_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            v1_q      <= rd_en;
            a1_q      <= rd_addr;
            wr_en_q   <= v1_q;
            wr_addr_q <= a1_q;
            wr_data_q <= sat_w;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_hidden_weight_update.sv
// -----------------------------------------------------------------------------
// tb_hidden_weight_update
//
// Drives hidden_weight_update (default parameters) against behavioural pixel
// and dual-port weight memories. Expected weights come from an integer model
// of the update rule (floor division by 2^LR_SHIFT, then clamp to 16 bits).
// -----------------------------------------------------------------------------
module tb_hidden_weight_update;

    localparam int N      = 784;
    localparam int DIVISOR = 256;   // 2^LR_SHIFT

    logic                clk = 1'b0;
    logic                reset_b;
    logic                start;
    logic signed [16:0]  derivative;
    logic                busy, done, rd_en, wr_en;
    logic [9:0]          rd_addr, wr_addr;
    logic [7:0]          pixel = '0;
    logic signed [15:0]  w_rd_data = '0;
    logic signed [15:0]  wr_data;

    logic [7:0]          pix_mem [0:1023];
    logic signed [15:0]  w_mem   [0:1023];
    int                  exp_w   [0:N-1];
    int                  orig_w  [0:N-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hidden_weight_update dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .start      (start),
        .derivative (derivative),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .pixel      (pixel),
        .w_rd_data  (w_rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // Registered-read pixel memory and dual-port weight memory.
    always @(posedge clk) begin
        if (rd_en) begin
            pixel     <= pix_mem[rd_addr];
            w_rd_data <= w_mem[rd_addr];
        end
        if (wr_en) begin
            w_mem[wr_addr] <= wr_data;
        end
    end

    function automatic int ref_w(input int d, input int p, input int w);
        longint prod, q, r;
        prod = longint'(d) * longint'(p);
        q = prod / DIVISOR;
        if (prod < 0 && (prod % DIVISOR) != 0) q = q - 1;
        r = longint'(w) - q;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_done"},    done,    0);
        chk({tag, "_rd_en"},   rd_en,   0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_wr_en"},   wr_en,   0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) begin
            pix_mem[i] = 8'($urandom_range(0, 255));
            w_mem[i]  <= 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic set_entry(input int i, input int p, input int w);
        pix_mem[i] = 8'(p);
        w_mem[i]  <= 16'(w);
    endtask

    // One update: start at the next edge, check every cycle through done,
    // then compare the whole weight memory. glitch_c: cycle in which a second
    // start is presented. reset_c: cycle in which reset is asserted.
    task automatic run(input int d, input int glitch_c, input int glitch_d,
                       input int reset_c);
        bit nz;
        int last, wr_limit;
        bit aborted;
        #1;
        for (int i = 0; i < N; i++) begin
            orig_w[i] = w_mem[i];
            exp_w[i]  = ref_w(d, int'(pix_mem[i]), int'(w_mem[i]));
        end
        nz       = (d != 0);
        last     = nz ? N + 2 : 1;
        aborted  = 1'b0;
        wr_limit = N;
        @(negedge clk);
        start      = 1'b1;
        derivative = 17'(d);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == reset_c) begin
                reset_b = 1'b0;
                #1;
                chk_idle_outputs("rst_mid");
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk("rst_hold_wr_en", wr_en, 0);
                end
                reset_b = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("post_rst_busy",  busy,  0);
                    chk("post_rst_rd_en", rd_en, 0);
                    chk("post_rst_wr_en", wr_en, 0);
                end
                aborted  = 1'b1;
                wr_limit = reset_c - 2;
                break;
            end
            chk($sformatf("busy@%0d", c),  busy,  nz ? (c <= N + 1) : (c == 0));
            chk($sformatf("done@%0d", c),  done,  c == last);
            chk($sformatf("rd_en@%0d", c), rd_en, nz && (c < N));
            if (nz && c < N) chk($sformatf("rd_addr@%0d", c), rd_addr, c);
            chk($sformatf("wr_en@%0d", c), wr_en, nz && c >= 2 && c <= N + 1);
            if (nz && c >= 2 && c <= N + 1) begin
                chk($sformatf("wr_addr@%0d", c), wr_addr, c - 2);
                chk($sformatf("wr_data@%0d", c), wr_data, exp_w[c - 2]);
            end
            start = (c == glitch_c);
            if (c == glitch_c) derivative = 17'(glitch_d);
        end
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("wmem[%0d]", i), w_mem[i],
                (i < wr_limit) ? exp_w[i] : orig_w[i]);
        end
        $display("run d=%0d glitch_c=%0d reset_c=%0d aborted=%0d total=%0d bad=%0d",
                 d, glitch_c, reset_c, aborted, total, bad);
    endtask

    initial begin
        int d;
        reset_b    = 1'b0;
        start      = 1'b0;
        derivative = '0;
        fill_random();
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset_b = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Basic update on indices 0..3.
        fill_random();
        set_entry(0, 0, 100);
        set_entry(1, 1, 100);
        set_entry(2, 255, 100);
        set_entry(3, 128, -50);
        run(256, -1, 0, -1);
        chk("basic_0", w_mem[0], 100);
        chk("basic_1", w_mem[1], 99);
        chk("basic_2", w_mem[2], -155);
        chk("basic_3", w_mem[3], -178);

        // Saturation at both rails.
        set_entry(0, 255, 32000);
        run(-65536, -1, 0, -1);
        chk("sat_hi", w_mem[0], 32767);
        set_entry(0, 255, -32000);
        run(65535, -1, 0, -1);
        chk("sat_lo", w_mem[0], -32768);

        // Floor behaviour of the arithmetic shift.
        set_entry(0, 1, 0);
        run(-1, -1, 0, -1);
        chk("floor_neg", w_mem[0], 1);
        set_entry(0, 1, 0);
        run(1, -1, 0, -1);
        chk("floor_pos", w_mem[0], 0);

        // Random derivatives over random memories.
        for (int k = 0; k < 3; k++) begin
            fill_random();
            d = int'($urandom_range(0, 131071)) - 65536;
            if (d == 0) d = 3;
            run(d, -1, 0, -1);
        end

        // Zero derivative: no traffic, done in cycle 1.
        fill_random();
        run(0, -1, 0, -1);

        // Start while busy is ignored.
        fill_random();
        run(-12345, 2, 20000, -1);

        // Reset mid-run at index 100, then a normal run afterwards.
        fill_random();
        run(30001, -1, 0, 100);
        fill_random();
        run(-777, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
